// File: rtl/generic_fifo_pkg.sv
// Shared types and helpers for the generic valid/grant stream FIFO.
// Holds the FSM state encoding and the pointer wrap rule.
package generic_fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    MIDDLE = 2'b01,
    FULL   = 2'b10
  } fifo_state_e;

  function automatic int unsigned ptr_inc(
    input int unsigned ptr,
    input int unsigned depth
  );
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Wrapping pointer register for the generic FIFO.
// Counts 0..DEPTH-1 on inc; clr takes priority and returns to 0.
module fifo_wrap_ptr
  import generic_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [AW-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= AW'(ptr_inc(32'(ptr), DEPTH));
    end
  end

endmodule

// File: rtl/generic_fifo_th.sv
// Valid/grant stream FIFO, any depth >= 2, with usage and threshold flags.
// Define GENERIC_FIFO_CG_EN to clock storage through cluster_clock_gating.
module generic_fifo_th
  import generic_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DATA_DEPTH   = 8,
  parameter int unsigned ALM_FULL_TH  = 6,
  parameter int unsigned ALM_EMPTY_TH = 2,
  localparam int unsigned AW = $clog2(DATA_DEPTH),
  localparam int unsigned CW = $clog2(DATA_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  test_mode_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  grant_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  grant_i,
  output logic [CW-1:0]         usage_o,
  output logic                  alm_full_o,
  output logic                  alm_empty_o
);

  fifo_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [0:DATA_DEPTH-1];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         usage_q;
  logic                  push, pop, clr;

  assign push = valid_i & grant_o;
  assign pop  = valid_o & grant_i;

  always_comb begin
    grant_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      EMPTY:  grant_o = 1'b1;
      MIDDLE: begin
        grant_o = 1'b1;
        valid_o = 1'b1;
      end
      FULL:   valid_o = 1'b1;
      default: ;
    endcase
    if (flush_i) begin
      grant_o = 1'b0;
      valid_o = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    clr     = flush_i;
    case (state_q)
      EMPTY: begin
        if (push) state_d = MIDDLE;
      end
      MIDDLE: begin
        if (push && !pop &&
            usage_q == CW'(DATA_DEPTH - 1))
          state_d = FULL;
        else if (pop && !push &&
                 usage_q == CW'(1))
          state_d = EMPTY;
      end
      FULL: begin
        if (pop) state_d = MIDDLE;
      end
      default: begin
        state_d = EMPTY;
        clr     = 1'b1;
      end
    endcase
    if (flush_i) state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      usage_q <= '0;
    end else begin
      state_q <= state_d;
      if (clr)
        usage_q <= '0;
      else if (push && !pop)
        usage_q <= usage_q + CW'(1);
      else if (pop && !push)
        usage_q <= usage_q - CW'(1);
    end
  end

  fifo_wrap_ptr #(.DEPTH(DATA_DEPTH)) i_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push),
    .clr   (clr),
    .ptr   (wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DATA_DEPTH)) i_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop),
    .clr   (clr),
    .ptr   (rd_ptr)
  );

`ifdef GENERIC_FIFO_CG_EN
  logic gclk;

  // Gate opens only on an accepted push, so no enable mux is needed.
  cluster_clock_gating i_cg (
    .clk_i     (clk),
    .en_i      (push),
    .test_en_i (test_mode_i),
    .clk_o     (gclk)
  );

  always_ff @(posedge gclk) begin
    mem[wr_ptr] <= data_i;
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode_i;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_i;
  end
`endif

  assign data_o      = mem[rd_ptr];
  assign usage_o     = usage_q;
  assign alm_full_o  = usage_q >= CW'(ALM_FULL_TH);
  assign alm_empty_o = usage_q <= CW'(ALM_EMPTY_TH);

endmodule

// File: tb/tb_generic_fifo_th.sv
// Randomised scoreboard bench for generic_fifo_th (depth 5, thresholds 4/1).
// A queue model predicts flags, handshakes and head data each cycle.
module tb_generic_fifo_th;

  localparam int DW  = 8;
  localparam int DEP = 5;
  localparam int AFT = 4;
  localparam int AET = 1;
  localparam int CW  = $clog2(DEP + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          test_mode_i;
  logic          flush_i;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          grant_o;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          grant_i;
  logic [CW-1:0] usage_o;
  logic          alm_full_o;
  logic          alm_empty_o;

  int checks = 0;
  int errors = 0;
  int popped = 0;
  int pushed = 0;

  logic [DW-1:0] mq[$];

  always #5 clk = ~clk;

  generic_fifo_th #(
    .DATA_WIDTH   (DW),
    .DATA_DEPTH   (DEP),
    .ALM_FULL_TH  (AFT),
    .ALM_EMPTY_TH (AET)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .test_mode_i (test_mode_i),
    .flush_i     (flush_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .grant_o     (grant_o),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .grant_i     (grant_i),
    .usage_o     (usage_o),
    .alm_full_o  (alm_full_o),
    .alm_empty_o (alm_empty_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs are stable from posedge+1 to the next posedge.
  always @(negedge clk) begin
    int  cnt;
    bit  eg, ev;
    if (!rst_n) begin
      chk("rst_valid", int'(valid_o), 0);
      chk("rst_grant", int'(grant_o), 1);
      chk("rst_usage", int'(usage_o), 0);
      chk("rst_alm_empty", int'(alm_empty_o), 1);
      chk("rst_alm_full", int'(alm_full_o), 0);
      mq.delete();
    end else begin
      cnt = mq.size();
      eg  = !flush_i && cnt < DEP;
      ev  = !flush_i && cnt > 0;
      chk("usage", int'(usage_o), cnt);
      chk("grant", int'(grant_o), int'(eg));
      chk("valid", int'(valid_o), int'(ev));
      chk("alm_full", int'(alm_full_o), int'(cnt >= AFT));
      chk("alm_empty", int'(alm_empty_o), int'(cnt <= AET));
      if (ev) chk("data", int'(data_o), int'(mq[0]));
      if (flush_i) begin
        mq.delete();
      end else begin
        if (ev && grant_i) begin
          void'(mq.pop_front());
          popped++;
        end
        if (eg && valid_i) begin
          mq.push_back(data_i);
          pushed++;
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [DW-1:0] d,
                       input bit g, input bit f);
    @(posedge clk);
    #1;
    valid_i = v;
    data_i  = d;
    grant_i = g;
    flush_i = f;
  endtask

  task automatic drain();
    repeat (DEP + 2) drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n       = 1'b0;
    test_mode_i = 1'b0;
    flush_i     = 1'b0;
    data_i      = '0;
    valid_i     = 1'b0;
    grant_i     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // single push with consumer stalled, then pop
    drive(1'b1, 8'hA1, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);

    // fill to full, extra pushes held off, then drain in order
    for (int i = 1; i <= DEP; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
    drive(1'b1, 8'h06, 1'b0, 1'b0);
    drive(1'b1, 8'h07, 1'b0, 1'b0);
    drain();

    // full with push and pop together: only the pop happens
    for (int i = 0; i < DEP; i++) drive(1'b1, DW'(8'h30 + i), 1'b0, 1'b0);
    drive(1'b1, 8'hEE, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    drain();

    // flush with usage 3, racing a push and a pop
    for (int i = 0; i < 3; i++) drive(1'b1, DW'(8'h50 + i), 1'b0, 1'b0);
    drive(1'b1, 8'h5F, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 8'h60, 1'b0, 1'b0);
    drain();

    // interleaved traffic across pointer wrap
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, DW'(8'h70 + i), 1'b0, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b0);
    end

    // random traffic with occasional flush
    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 3) != 0, DW'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    drain();

    // asynchronous reset while holding three entries
    for (int i = 0; i < 3; i++) drive(1'b1, DW'(8'h90 + i), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(valid_o), 0);
    chk("async_rst_grant", int'(grant_o), 1);
    chk("async_rst_usage", int'(usage_o), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, 8'hB7, 1'b0, 1'b0);
    drain();

    chk("transfers_nonzero", int'(popped > 20), 1);
    chk("final_usage", int'(usage_o), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
